// File: rtl/arbiter_n_to_1_weighted_request.sv
// N-to-1 request arbiter: per-channel FWFT FIFOs merged onto one valid/ready stream,
// with fixed-priority, round-robin or weighted round-robin (burst credit) arbitration.

module arb_chan_fifo #(
  parameter int DEPTH  = 16,
  parameter int W      = 64,
  parameter int THRESH = 12
)(
  input  logic         ap_clk,
  input  logic         areset,
  input  logic         push_req,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic         nonempty,
  output logic         ready,
  output logic         overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          full, push;

  // A write into a full FIFO is still taken when the head leaves in the same cycle.
  assign full     = (cnt == CW'(DEPTH));
  assign push     = push_req & (~full | pop);
  assign nonempty = (cnt != '0);
  assign head     = mem[rd_ptr];

  always_ff @(posedge ap_clk) begin
    if (push && !areset) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      ready    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      ready <= (cnt < CW'(THRESH));
      if (push_req && full && !pop) overflow <= 1'b1;
    end
  end
endmodule

module arbiter_n_to_1_weighted_request #(
  parameter int NUM_REQUESTOR = 4,
  parameter int DATA_WIDTH    = 64,
  parameter int FIFO_DEPTH    = 16,
  parameter int PROG_THRESH   = 12,
  parameter int ARB_MODE      = 2,
  parameter int WEIGHT_WIDTH  = 4,
  parameter int ID_W          = $clog2(NUM_REQUESTOR)
)(
  input  logic                                  ap_clk,
  input  logic                                  areset,
  input  logic [NUM_REQUESTOR-1:0]              req_valid_in,
  input  logic [NUM_REQUESTOR*DATA_WIDTH-1:0]   req_data_in,
  output logic [NUM_REQUESTOR-1:0]              req_ready_out,
  input  logic [NUM_REQUESTOR*WEIGHT_WIDTH-1:0] weight_in,
  output logic                                  out_valid,
  output logic [DATA_WIDTH-1:0]                 out_data,
  output logic [ID_W-1:0]                       out_source_id,
  input  logic                                  out_ready,
  output logic [NUM_REQUESTOR-1:0]              overflow_out,
  output logic                                  fifo_setup_signal
);
  typedef struct packed {
    logic [ID_W-1:0]       id;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  logic [NUM_REQUESTOR-1:0][DATA_WIDTH-1:0]   data_in, head;
  logic [NUM_REQUESTOR-1:0][WEIGHT_WIDTH-1:0] weight;
  logic [NUM_REQUESTOR-1:0]                   ne, pop;

  assign data_in = req_data_in;
  assign weight  = weight_in;

  for (genvar g = 0; g < NUM_REQUESTOR; g++) begin : g_lane
    arb_chan_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .W      (DATA_WIDTH),
      .THRESH (PROG_THRESH)
    ) u_fifo (
      .ap_clk   (ap_clk),
      .areset   (areset),
      .push_req (req_valid_in[g]),
      .pop      (pop[g]),
      .wdata    (data_in[g]),
      .head     (head[g]),
      .nonempty (ne[g]),
      .ready    (req_ready_out[g]),
      .overflow (overflow_out[g])
    );
  end

  state_t                  state_q, state_d;
  logic [ID_W-1:0]         last_grant_q, last_grant_d;
  logic [ID_W-1:0]         cur_q, cur_d;
  logic [WEIGHT_WIDTH-1:0] credit_q, credit_d, w_eff;
  logic [ID_W-1:0]         fp_sel, rr_sel, rr_idx, sel;
  logic                    rr_found, grant, can_load, any_ne;
  beat_t                   out_q;
  logic                    out_vld_q, setup_q;

  assign any_ne   = |ne;
  assign can_load = ~out_vld_q | out_ready;

  always_comb begin
    fp_sel = '0;
    for (int i = NUM_REQUESTOR - 1; i >= 0; i--) begin
      if (ne[i]) fp_sel = ID_W'(i);
    end
  end

  // First non-empty channel strictly after last_grant, wrapping.
  always_comb begin
    rr_sel   = '0;
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int k = 1; k <= NUM_REQUESTOR; k++) begin
      rr_idx = ID_W'((int'(last_grant_q) + k) % NUM_REQUESTOR);
      if (!rr_found && ne[rr_idx]) begin
        rr_found = 1'b1;
        rr_sel   = rr_idx;
      end
    end
  end

  always_comb begin
    grant        = 1'b0;
    sel          = '0;
    state_d      = state_q;
    cur_d        = cur_q;
    credit_d     = credit_q;
    last_grant_d = last_grant_q;
    w_eff        = weight[rr_sel];
    if (w_eff == '0) w_eff = WEIGHT_WIDTH'(1);
    if (ARB_MODE == 0) begin
      if (any_ne && can_load) begin
        grant = 1'b1;
        sel   = fp_sel;
      end
    end else if (ARB_MODE == 1) begin
      if (any_ne && can_load) begin
        grant        = 1'b1;
        sel          = rr_sel;
        last_grant_d = rr_sel;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_ne && can_load) begin
            grant        = 1'b1;
            sel          = rr_sel;
            cur_d        = rr_sel;
            last_grant_d = rr_sel;
            credit_d     = w_eff - 1'b1;
            state_d      = (credit_d != '0) ? S_BURST : S_IDLE;
          end
        end
        S_BURST: begin
          // An empty channel at a load opportunity ends the burst without a grant.
          if (can_load) begin
            if (ne[cur_q]) begin
              grant    = 1'b1;
              sel      = cur_q;
              credit_d = credit_q - 1'b1;
              if (credit_q == WEIGHT_WIDTH'(1)) begin
                state_d      = S_IDLE;
                last_grant_d = cur_q;
              end
            end else begin
              state_d      = S_IDLE;
              last_grant_d = cur_q;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign pop = grant ? (NUM_REQUESTOR'(1) << sel) : '0;

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q      <= S_IDLE;
      cur_q        <= '0;
      credit_q     <= '0;
      last_grant_q <= ID_W'(NUM_REQUESTOR - 1);
      out_vld_q    <= 1'b0;
      out_q        <= '0;
      setup_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      credit_q     <= credit_d;
      last_grant_q <= last_grant_d;
      setup_q      <= 1'b0;
      if (can_load) begin
        out_vld_q <= grant;
        if (grant) out_q <= '{id: sel, data: head[sel]};
      end
    end
  end

  assign out_valid         = out_vld_q;
  assign out_data          = out_q.data;
  assign out_source_id     = out_q.id;
  assign fifo_setup_signal = setup_q;
endmodule

// File: tb/tb_arbiter_n_to_1_weighted_request.sv
// Bench for the weighted request arbiter: one DUT per arbitration mode on shared inputs,
// checked against a transaction-level model of the grant order.
module tb_arbiter_n_to_1_weighted_request;
  localparam int N   = 4;
  localparam int DW  = 64;
  localparam int WW  = 4;
  localparam int IDW = 2;

  logic            ap_clk = 1'b0;
  logic            areset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N*WW-1:0] weight = '0;
  logic            out_ready = 1'b0;

  logic [N-1:0]   rdy   [3];
  logic           ov    [3];
  logic [DW-1:0]  od    [3];
  logic [IDW-1:0] oid   [3];
  logic [N-1:0]   ovf   [3];
  logic           setup [3];

  int errors = 0;
  int checks = 0;
  int wts[N];
  logic [DW-1:0]  pl_q[N][$];
  logic [IDW-1:0] exp_id[$];
  logic [DW-1:0]  exp_data[$];
  logic [IDW-1:0] seen_id[$];
  int rr_ids[8]   = '{0, 1, 2, 3, 0, 1, 2, 3};
  int wrr_ids[11] = '{0, 0, 0, 1, 2, 3, 3, 0, 0, 0, 1};

  always #5 ap_clk = ~ap_clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    arbiter_n_to_1_weighted_request #(
      .NUM_REQUESTOR (N), .DATA_WIDTH (DW), .FIFO_DEPTH (16), .PROG_THRESH (12),
      .ARB_MODE (g), .WEIGHT_WIDTH (WW), .ID_W (IDW)
    ) u_dut (
      .ap_clk            (ap_clk),
      .areset            (areset),
      .req_valid_in      (req_valid),
      .req_data_in       (req_data),
      .req_ready_out     (rdy[g]),
      .weight_in         (weight),
      .out_valid         (ov[g]),
      .out_data          (od[g]),
      .out_source_id     (oid[g]),
      .out_ready         (out_ready),
      .overflow_out      (ovf[g]),
      .fifo_setup_signal (setup[g])
    );
  end

  task automatic set_weights(input int w0, input int w1, input int w2, input int w3);
    wts = '{w0, w1, w2, w3};
    for (int i = 0; i < N; i++) weight[i*WW +: WW] = WW'(wts[i]);
  endtask

  task automatic do_reset();
    areset    = 1'b1;
    req_valid = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge ap_clk);
    areset = 1'b0;
    @(negedge ap_clk);
    exp_id.delete();
    exp_data.delete();
  endtask

  // Drives each channel's beats on consecutive cycles, all channels starting together.
  task automatic preload(input int c0, input int c1, input int c2, input int c3);
    int cnt[N];
    int mx;
    cnt = '{c0, c1, c2, c3};
    mx  = 0;
    for (int i = 0; i < N; i++) begin
      pl_q[i].delete();
      if (cnt[i] > mx) mx = cnt[i];
    end
    for (int c = 0; c < mx; c++) begin
      for (int i = 0; i < N; i++) begin
        if (c < cnt[i]) begin
          logic [DW-1:0] d;
          d = {$urandom, $urandom};
          req_valid[i]          = 1'b1;
          req_data[i*DW +: DW]  = d;
          pl_q[i].push_back(d);
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      @(negedge ap_clk);
    end
    req_valid = '0;
  endtask

  // Grant order when every channel's beats are already queued.
  task automatic build_expected(input int mode);
    logic [DW-1:0] q[N][$];
    int last;
    int sel;
    int n;
    for (int i = 0; i < N; i++) q[i] = pl_q[i];
    last = N - 1;
    exp_id.delete();
    exp_data.delete();
    while (1) begin
      sel = -1;
      if (mode == 0) begin
        for (int i = N - 1; i >= 0; i--) if (q[i].size() > 0) sel = i;
      end else begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (last + k) % N;
          if (sel < 0 && q[c].size() > 0) sel = c;
        end
      end
      if (sel < 0) break;
      n = (mode == 2) ? ((wts[sel] == 0) ? 1 : wts[sel]) : 1;
      for (int j = 0; j < n && q[sel].size() > 0; j++) begin
        exp_id.push_back(IDW'(sel));
        exp_data.push_back(q[sel].pop_front());
      end
      last = sel;
    end
  endtask

  task automatic drain(input int m, input int ready_pct, output int cyc);
    cyc = 0;
    seen_id.delete();
    for (int t = 0; t < 600 && exp_id.size() > 0; t++) begin
      out_ready = ($urandom_range(99) < ready_pct);
      if (ov[m]) begin
        checks++;
        if (oid[m] !== exp_id[0] || od[m] !== exp_data[0]) begin
          errors++;
          $display("FAIL beat mode=%0d: got id=%0d data=%h, want id=%0d data=%h",
                   m, oid[m], od[m], exp_id[0], exp_data[0]);
        end
        if (out_ready) begin
          seen_id.push_back(oid[m]);
          void'(exp_id.pop_front());
          void'(exp_data.pop_front());
        end
      end
      cyc++;
      @(negedge ap_clk);
    end
    checks++;
    if (exp_id.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout mode=%0d: %0d beats still expected, want 0", m, exp_id.size());
    end
    checks++;
    if (ov[m] !== 1'b0) begin
      errors++;
      $display("FAIL extra_beat mode=%0d: out_valid=%b id=%0d, want out_valid=0", m, ov[m], oid[m]);
    end
    out_ready = 1'b0;
  endtask

  task automatic check_reset_vals(input int g, input string tag);
    checks++;
    if (ov[g] !== 1'b0 || od[g] !== '0 || oid[g] !== '0 || rdy[g] !== '0 ||
        ovf[g] !== '0 || setup[g] !== 1'b1) begin
      errors++;
      $display("FAIL %s dut%0d: valid=%b data=%h id=%0d ready=%b ovf=%b setup=%b, want 0/0/0/0000/0000/1",
               tag, g, ov[g], od[g], oid[g], rdy[g], ovf[g], setup[g]);
    end
  endtask

  task automatic check_release(input int g, input string tag);
    checks++;
    if (setup[g] !== 1'b0 || rdy[g] !== 4'hF || ov[g] !== 1'b0) begin
      errors++;
      $display("FAIL %s dut%0d: setup=%b ready=%b valid=%b, want setup=0 ready=1111 valid=0",
               tag, g, setup[g], rdy[g], ov[g]);
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (2) @(negedge ap_clk);
    for (int g = 0; g < 3; g++) check_reset_vals(g, "reset_values");
    areset = 1'b0;
    @(negedge ap_clk);
    for (int g = 0; g < 3; g++) check_release(g, "reset_release");
  endtask

  task automatic test_fixed_priority();
    int ids[8] = '{0, 0, 0, 0, 2, 2, 2, 0};
    int bts[8] = '{0, 0, 1, 2, 0, 1, 2, 0};
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      logic exp_v;
      logic [DW-1:0] exp_d;
      if (c < 3) begin
        req_valid = 4'b0101;
        req_data[0*DW +: DW] = DW'(64'h100 + c);
        req_data[2*DW +: DW] = DW'(64'h200 + c);
      end else begin
        req_valid = '0;
      end
      @(negedge ap_clk);
      exp_v = (c >= 1 && c <= 6);
      exp_d = DW'(64'h100 * (ids[c] == 0 ? 1 : 2) + bts[c]);
      checks++;
      if (ov[0] !== exp_v || (exp_v && (oid[0] !== IDW'(ids[c]) || od[0] !== exp_d))) begin
        errors++;
        $display("FAIL fixed_priority cycle%0d: valid=%b id=%0d data=%h, want valid=%b id=%0d data=%h",
                 c, ov[0], oid[0], od[0], exp_v, ids[c], exp_d);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    int cyc;
    do_reset();
    preload(2, 2, 2, 2);
    build_expected(1);
    drain(1, 100, cyc);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= seen_id.size() || seen_id[i] !== IDW'(rr_ids[i])) begin
        errors++;
        $display("FAIL round_robin_order[%0d]: got %0d, want %0d", i,
                 (i < seen_id.size()) ? int'(seen_id[i]) : -1, rr_ids[i]);
      end
    end
  endtask

  task automatic test_weighted();
    int cyc;
    do_reset();
    set_weights(3, 1, 0, 2);
    preload(6, 6, 6, 6);
    build_expected(2);
    drain(2, 100, cyc);
    checks++;
    if (cyc != 24) begin
      errors++;
      $display("FAIL wrr_throughput: took %0d cycles, want 24", cyc);
    end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (i >= seen_id.size() || seen_id[i] !== IDW'(wrr_ids[i])) begin
        errors++;
        $display("FAIL wrr_order[%0d]: got %0d, want %0d", i,
                 (i < seen_id.size()) ? int'(seen_id[i]) : -1, wrr_ids[i]);
      end
    end
  endtask

  task automatic test_stall();
    int cyc;
    do_reset();
    preload(2, 2, 2, 2);
    build_expected(1);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge ap_clk);
      checks++;
      if (ov[1] !== 1'b1 || oid[1] !== exp_id[0] || od[1] !== exp_data[0]) begin
        errors++;
        $display("FAIL stall_hold cycle%0d: valid=%b id=%0d data=%h, want valid=1 id=%0d data=%h",
                 c, ov[1], oid[1], od[1], exp_id[0], exp_data[0]);
      end
    end
    drain(1, 100, cyc);
  endtask

  task automatic test_overflow();
    int cyc;
    logic [DW-1:0] d0;
    do_reset();
    d0 = {$urandom, $urandom};
    req_valid[0] = 1'b1;
    req_data[0 +: DW] = d0;
    @(negedge ap_clk);
    req_valid = '0;
    @(negedge ap_clk);
    for (int w = 1; w <= 18; w++) begin
      req_valid[1] = 1'b1;
      req_data[DW +: DW] = DW'(64'hA000 + w);
      @(negedge ap_clk);
      if (w == 11 || w == 13) begin
        checks++;
        if (rdy[0][1] !== (w == 11)) begin
          errors++;
          $display("FAIL ovf_ready after write %0d: ready=%b, want %b", w, rdy[0][1], (w == 11));
        end
      end
      if (w == 16 || w == 17) begin
        checks++;
        if (ovf[0] !== ((w == 17) ? 4'b0010 : 4'b0000)) begin
          errors++;
          $display("FAIL ovf_flag after write %0d: overflow=%b, want %b", w, ovf[0],
                   (w == 17) ? 4'b0010 : 4'b0000);
        end
      end
    end
    req_valid = '0;
    repeat (3) @(negedge ap_clk);
    exp_id.delete();
    exp_data.delete();
    exp_id.push_back(2'd0);
    exp_data.push_back(d0);
    for (int w = 1; w <= 16; w++) begin
      exp_id.push_back(2'd1);
      exp_data.push_back(DW'(64'hA000 + w));
    end
    drain(0, 100, cyc);
    checks++;
    if (ovf[0] !== 4'b0010) begin
      errors++;
      $display("FAIL ovf_sticky: overflow=%b, want 0010", ovf[0]);
    end
    do_reset();
    checks++;
    if (ovf[0] !== 4'b0000) begin
      errors++;
      $display("FAIL ovf_clear: overflow=%b, want 0000", ovf[0]);
    end
  endtask

  task automatic test_reset_mid_burst();
    int cyc;
    do_reset();
    set_weights(5, 1, 1, 1);
    preload(6, 6, 6, 6);
    out_ready = 1'b1;
    repeat (2) @(negedge ap_clk);
    areset    = 1'b1;
    out_ready = 1'b0;
    @(negedge ap_clk);
    check_reset_vals(2, "midburst_reset");
    areset = 1'b0;
    @(negedge ap_clk);
    check_release(2, "midburst_release");
    set_weights(1, 1, 1, 1);
    preload(1, 1, 0, 1);
    build_expected(2);
    drain(2, 100, cyc);
    checks++;
    if (seen_id.size() != 3 || seen_id[0] !== 2'd0) begin
      errors++;
      $display("FAIL midburst_restart: %0d beats first id=%0d, want 3 beats first id=0",
               seen_id.size(), (seen_id.size() > 0) ? int'(seen_id[0]) : -1);
    end
  endtask

  task automatic test_random();
    int cyc;
    for (int it = 0; it < 6; it++) begin
      for (int m = 0; m < 3; m++) begin
        do_reset();
        set_weights($urandom_range(3), $urandom_range(3), $urandom_range(3), $urandom_range(3));
        preload($urandom_range(6), $urandom_range(6), $urandom_range(6), $urandom_range(6));
        build_expected(m);
        drain(m, 60, cyc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_weighted();
    test_stall();
    test_overflow();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end
endmodule
